// File: rtl/vector_sequencer.sv
// vector_sequencer: walks a vector ROM one object at a time and hands the
// offset-adjusted points to a drawer through a valid/ready handshake.
// Optional build macro VECSEQ_CLIP_EN: offset additions saturate at 255
// instead of wrapping modulo 256.
module vector_sequencer #(
    parameter int ADDRESSWIDTH = 16,
    parameter int DATAWIDTH    = 18,
    parameter int NOBJ         = 4,
    parameter logic [NOBJ*ADDRESSWIDTH-1:0] BASE = {16'd54, 16'd48, 16'd42, 16'd0},
    parameter int MAXLEN       = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NOBJ-1:0]         obj_en,
    input  logic [NOBJ*8-1:0]       off_x,
    input  logic [NOBJ*8-1:0]       off_y,
    output logic [ADDRESSWIDTH-1:0] rom_addr,
    input  logic [DATAWIDTH-1:0]    rom_data,
    output logic [7:0]              vec_x,
    output logic [7:0]              vec_y,
    output logic                    vec_line,
    output logic                    vec_pos,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err
);

    localparam int OBJW = (NOBJ > 1) ? $clog2(NOBJ) : 1;
    localparam int CNTW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NOBJ-1:0]         en_q, en_d;
    logic [OBJW-1:0]         obj_q, obj_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [ADDRESSWIDTH-1:0] addr_d;
    logic [7:0]              x_d, y_d;
    logic                    line_d, pos_d, valid_d, busy_d, done_d, err_d;

    logic [7:0]              ent_x, ent_y, ox, oy, sum_x, sum_y;
    logic                    ent_line, ent_pos, ent_end;
    logic [NOBJ-1:0]         rest;
    logic [OBJW:0]           first_pick, next_pick;

    // Lowest set bit of a mask as {found, index}.
    function automatic logic [OBJW:0] lowest(input logic [NOBJ-1:0] m);
        logic [OBJW:0] r;
        r = '0;
        for (int unsigned i = 0; i < NOBJ; i++) begin
            if (m[i] && !r[OBJW]) r = {1'b1, OBJW'(i)};
        end
        return r;
    endfunction

    function automatic logic [ADDRESSWIDTH-1:0] base_of(input logic [OBJW-1:0] idx);
        return BASE[idx*ADDRESSWIDTH +: ADDRESSWIDTH];
    endfunction

    function automatic logic [7:0] add_off(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef VECSEQ_CLIP_EN
        return s[8] ? 8'hFF : s[7:0];
`else
        return s[7:0];
`endif
    endfunction

    // Decode the current ROM word and select the current object's offsets.
    always_comb begin
        ent_x      = rom_data[DATAWIDTH-1 -: 8];
        ent_y      = rom_data[DATAWIDTH-9 -: 8];
        ent_line   = rom_data[1];
        ent_pos    = rom_data[0];
        ent_end    = (ent_line && ent_pos) || (rom_data == '0);
        ox         = off_x[obj_q*8 +: 8];
        oy         = off_y[obj_q*8 +: 8];
        sum_x      = add_off(ent_x, ox);
        sum_y      = add_off(ent_y, oy);
        rest       = en_q;
        rest[obj_q] = 1'b0;
        first_pick = lowest(obj_en);
        next_pick  = lowest(rest);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        obj_d   = obj_q;
        cnt_d   = cnt_q;
        addr_d  = rom_addr;
        x_d     = vec_x;
        y_d     = vec_y;
        line_d  = vec_line;
        pos_d   = vec_pos;
        valid_d = vec_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;
        case (state_q)
            IDLE: begin
                // frame_done high means DONE was just left; a start in that
                // cycle belongs to the finished frame and is dropped.
                if (start && !frame_done) begin
                    en_d   = obj_en;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    if (first_pick[OBJW]) begin
                        obj_d   = first_pick[OBJW-1:0];
                        addr_d  = base_of(first_pick[OBJW-1:0]);
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (ent_end || cnt_q == CNTW'(MAXLEN)) begin
                    if (!ent_end) err_d = 1'b1;
                    en_d[obj_q] = 1'b0;
                    cnt_d       = '0;
                    if (next_pick[OBJW]) begin
                        obj_d  = next_pick[OBJW-1:0];
                        addr_d = base_of(next_pick[OBJW-1:0]);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    x_d     = sum_x;
                    y_d     = sum_y;
                    line_d  = ent_line;
                    pos_d   = ent_pos;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (vec_ready) begin
                    valid_d = 1'b0;
                    addr_d  = rom_addr + ADDRESSWIDTH'(1);
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = FETCH;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q       <= '0;
            obj_q      <= '0;
            cnt_q      <= '0;
            rom_addr   <= '0;
            vec_x      <= '0;
            vec_y      <= '0;
            vec_line   <= 1'b0;
            vec_pos    <= 1'b0;
            vec_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            en_q       <= en_d;
            obj_q      <= obj_d;
            cnt_q      <= cnt_d;
            rom_addr   <= addr_d;
            vec_x      <= x_d;
            vec_y      <= y_d;
            vec_line   <= line_d;
            vec_pos    <= pos_d;
            vec_valid  <= valid_d;
            busy       <= busy_d;
            frame_done <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: scoreboard bench for vector_sequencer. Expected points
// are queued by the stimulus; monitors pop and compare on each handshake.
module tb_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, vec_ready;
    logic [3:0]  obj_en;
    logic [31:0] off_x, off_y;
    logic [15:0] rom_addr;
    logic [17:0] rom_data;
    logic [7:0]  vec_x, vec_y;
    logic        vec_line, vec_pos, vec_valid, busy, frame_done, err;

    logic        start4, ready4;
    logic [3:0]  obj_en4;
    logic [31:0] off4;
    logic [15:0] rom_addr4;
    logic [17:0] rom_data4;
    logic [7:0]  vec_x4, vec_y4;
    logic        vec_line4, vec_pos4, vec_valid4, busy4, frame_done4, err4;

    int n_total = 0;
    int n_pass  = 0;
    logic [17:0] q[$];
    logic [17:0] q4[$];
    logic [17:0] held;
    logic        hold_pending = 1'b0;
    bit          toggle = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [17:0] pt(input int x, input int y, input int l, input int p);
        return {x[7:0], y[7:0], l[0], p[0]};
    endfunction

    // Vector ROM contents: obj0 @0 (3 pts), frame @42, cursor @48,
    // an unterminated run of 10 points @54 followed by zeros.
    function automatic logic [17:0] rom(input logic [15:0] a);
        case (a)
            16'd0:  return pt(10, 20, 0, 1);
            16'd1:  return pt(30, 20, 1, 0);
            16'd2:  return pt(30, 40, 1, 0);
            16'd3:  return pt(77, 77, 1, 1);
            16'd42: return pt(5, 5, 0, 1);
            16'd43: return pt(250, 5, 1, 0);
            16'd44: return pt(250, 250, 1, 0);
            16'd45: return pt(5, 250, 1, 0);
            16'd46: return pt(5, 5, 1, 0);
            16'd47: return pt(0, 0, 1, 1);
            16'd48: return pt(22, 50, 0, 1);
            16'd49: return pt(46, 46, 1, 0);
            16'd50: return pt(36, 40, 1, 0);
            16'd51: return pt(35, 29, 1, 0);
            16'd52: return pt(22, 50, 1, 0);
            16'd53: return pt(9, 9, 1, 1);
            default: begin
                if (a >= 16'd54 && a <= 16'd63)
                    return pt(100 + int'(a) - 54, 200 - (int'(a) - 54), (a != 16'd54) ? 1 : 0, (a == 16'd54) ? 1 : 0);
                return '0;
            end
        endcase
    endfunction

    assign rom_data  = rom(rom_addr);
    assign rom_data4 = rom(rom_addr4);

    vector_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .obj_en(obj_en),
        .off_x(off_x), .off_y(off_y), .rom_addr(rom_addr), .rom_data(rom_data),
        .vec_x(vec_x), .vec_y(vec_y), .vec_line(vec_line), .vec_pos(vec_pos),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    vector_sequencer #(
        .BASE({16'd0, 16'd0, 16'd0, 16'd54}),
        .MAXLEN(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .obj_en(obj_en4),
        .off_x(off4), .off_y(off4), .rom_addr(rom_addr4), .rom_data(rom_data4),
        .vec_x(vec_x4), .vec_y(vec_y4), .vec_line(vec_line4), .vec_pos(vec_pos4),
        .vec_valid(vec_valid4), .vec_ready(ready4), .busy(busy4),
        .frame_done(frame_done4), .err(err4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Main-DUT monitor: compares each accepted point and checks hold stability.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && vec_valid) begin
            if (hold_pending)
                chk("hold_stable", {14'd0, vec_x, vec_y, vec_line, vec_pos}, {14'd0, held});
            if (vec_ready) begin
                hold_pending = 1'b0;
                if (q.size() == 0) chk("unexpected_point", {14'd0, vec_x, vec_y, vec_line, vec_pos}, 32'hFFFF_FFFF);
                else begin
                    e = q.pop_front();
                    chk("point", {14'd0, vec_x, vec_y, vec_line, vec_pos}, {14'd0, e});
                end
            end else begin
                hold_pending = 1'b1;
                held = {vec_x, vec_y, vec_line, vec_pos};
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Second-DUT monitor (MAXLEN=4 instance, drawer always ready).
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && vec_valid4 && ready4) begin
            if (q4.size() == 0) chk("unexpected_point4", {14'd0, vec_x4, vec_y4, vec_line4, vec_pos4}, 32'hFFFF_FFFF);
            else begin
                e = q4.pop_front();
                chk("point4", {14'd0, vec_x4, vec_y4, vec_line4, vec_pos4}, {14'd0, e});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] en);
        obj_en = en;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n;
        for (n = 0; n < 3000; n++) begin
            if ((sel ? frame_done4 : frame_done) == 1'b1) break;
            if (toggle) vec_ready = ~vec_ready;
            cyc();
        end
        chk(sel ? "frame_done4_seen" : "frame_done_seen", {31'd0, sel ? frame_done4 : frame_done}, 32'd1);
    endtask

    task automatic push_frame();
        q.push_back(pt(5, 5, 0, 1));
        q.push_back(pt(250, 5, 1, 0));
        q.push_back(pt(250, 250, 1, 0));
        q.push_back(pt(5, 250, 1, 0));
        q.push_back(pt(5, 5, 1, 0));
    endtask

    task automatic push_cursor();
        q.push_back(pt(22, 50, 0, 1));
        q.push_back(pt(46, 46, 1, 0));
        q.push_back(pt(36, 40, 1, 0));
        q.push_back(pt(35, 29, 1, 0));
        q.push_back(pt(22, 50, 1, 0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; vec_ready = 1'b1; obj_en = '0;
        off_x = '0; off_y = '0;
        start4 = 1'b0; ready4 = 1'b1; obj_en4 = '0; off4 = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, vec_valid}, 32'd0);
        chk("rst_addr", {16'd0, rom_addr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_xy", {16'd0, vec_x, vec_y}, 32'd0);

        // Cursor only, zero offsets; includes latency and busy-start checks.
        push_cursor();
        do_start(4'b0100);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_addr", {16'd0, rom_addr}, 32'd48);
        chk("start_valid0", {31'd0, vec_valid}, 32'd0);
        cyc();
        chk("first_valid", {31'd0, vec_valid}, 32'd1);
        do_start(4'b1111);
        wait_done(1'b0);
        chk("cursor_drained", q.size(), 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        cyc();

        // No objects enabled; start during the frame_done cycle is dropped.
        do_start(4'b0000);
        chk("empty_done_early", {31'd0, frame_done}, 32'd0);
        cyc();
        chk("empty_done", {31'd0, frame_done}, 32'd1);
        chk("empty_busy", {31'd0, busy}, 32'd0);
        do_start(4'b0100);
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        cyc();
        chk("still_idle", {31'd0, busy}, 32'd0);

        // Frame then cursor with a toggling drawer.
        push_frame();
        push_cursor();
        vec_ready = 1'b0;
        toggle = 1'b1;
        do_start(4'b0110);
        wait_done(1'b0);
        chk("frame_cursor_drained", q.size(), 32'd0);
        toggle = 1'b0;
        vec_ready = 1'b1;
        cyc();

        // Cursor with offsets x=250, y=10.
`ifdef VECSEQ_CLIP_EN
        q.push_back(pt(255, 60, 0, 1));
        q.push_back(pt(255, 56, 1, 0));
        q.push_back(pt(255, 50, 1, 0));
        q.push_back(pt(255, 39, 1, 0));
        q.push_back(pt(255, 60, 1, 0));
`else
        q.push_back(pt(16, 60, 0, 1));
        q.push_back(pt(40, 56, 1, 0));
        q.push_back(pt(30, 50, 1, 0));
        q.push_back(pt(29, 39, 1, 0));
        q.push_back(pt(16, 60, 1, 0));
`endif
        off_x = 32'h00FA_0000;
        off_y = 32'h000A_0000;
        do_start(4'b0100);
        wait_done(1'b0);
        chk("offset_drained", q.size(), 32'd0);
        off_x = '0; off_y = '0;
        cyc();

        // Zero word ends object 3 after 10 points, without err.
        for (int i = 0; i < 10; i++) q.push_back(pt(100 + i, 200 - i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0));
        do_start(4'b1000);
        wait_done(1'b0);
        chk("zero_term_drained", q.size(), 32'd0);
        chk("zero_term_no_err", {31'd0, err}, 32'd0);
        cyc();

        // MAXLEN=4 instance: runaway object then a normal one.
        for (int i = 0; i < 4; i++) q4.push_back(pt(100 + i, 200 - i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0));
        q4.push_back(pt(10, 20, 0, 1));
        q4.push_back(pt(30, 20, 1, 0));
        q4.push_back(pt(30, 40, 1, 0));
        obj_en4 = 4'b0011;
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        wait_done(1'b1);
        chk("runaway_drained", q4.size(), 32'd0);
        chk("runaway_err", {31'd0, err4}, 32'd1);
        cyc();
        q4.push_back(pt(10, 20, 0, 1));
        q4.push_back(pt(30, 20, 1, 0));
        q4.push_back(pt(30, 40, 1, 0));
        obj_en4 = 4'b0010;
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        chk("err_cleared", {31'd0, err4}, 32'd0);
        wait_done(1'b1);
        chk("second4_drained", q4.size(), 32'd0);
        cyc();

        // Reset while a point is held in EMIT, then restart.
        push_cursor();
        vec_ready = 1'b0;
        do_start(4'b0100);
        cyc();
        chk("emit_valid", {31'd0, vec_valid}, 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("emit_rst_valid", {31'd0, vec_valid}, 32'd0);
        chk("emit_rst_outs", {rom_addr, vec_x, vec_y}, 32'd0);
        chk("emit_rst_flags", {27'd0, vec_line, vec_pos, busy, frame_done, err}, 32'd0);
        rst_n = 1'b1;
        q.delete();
        push_cursor();
        vec_ready = 1'b1;
        do_start(4'b0100);
        chk("restart_addr", {16'd0, rom_addr}, 32'd48);
        wait_done(1'b0);
        chk("restart_drained", q.size(), 32'd0);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
